// File: rtl/mdio_reg_responder_if.sv
// Local host port of the MDIO register responder: single-cycle strobed
// register access from FPGA-side logic.
`timescale 1ns/1ps
interface mdio_reg_responder_if;
  logic [4:0]  loc_addr_i;
  logic [15:0] loc_data_i;
  logic        loc_we_i;
  logic        loc_stb_i;
  logic [15:0] loc_data_o;
  logic        loc_ack_o;

  modport master (
    output loc_addr_i, loc_data_i, loc_we_i, loc_stb_i,
    input  loc_data_o, loc_ack_o
  );

  modport slave (
    input  loc_addr_i, loc_data_i, loc_we_i, loc_stb_i,
    output loc_data_o, loc_ack_o
  );
endinterface

// File: rtl/mdio_reg_responder.sv
// Clause-22 MDIO responder (PHY side): oversamples MDC/MDIO, decodes frames for
// its PHY address and serves a 32 x 16-bit register file shared with a local port.
`timescale 1ns/1ps
module mdio_reg_responder #(
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h001C,
  parameter logic [15:0] PHY_ID2      = 16'hC915
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       mdc_i,
  input  logic       mdio_i,
  output logic       mdio_o,
  output logic       mdio_oe,
  input  logic [4:0] phy_addr_i,
  mdio_reg_responder_if.slave loc,
  output logic       frame_done_o,
  output logic       frame_err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_SKIP, S_TA, S_RDATA, S_WDATA
  } state_e;

  localparam int            PW      = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_MIN);

  logic [2:0]  mdc_sync_q;
  logic [1:0]  mdio_sync_q;
  logic        bit_evt, bit_val;

  state_e      state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        is_read_q, is_read_d;
  logic [4:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] shift_q, shift_d;
  logic        oe_q, oe_d, mdo_q, mdo_d;
  logic        done_q, done_d, err_q, err_d;
  logic        mdio_we;
  logic [15:0] mdio_wdata;

  logic [31:0][15:0] rf_rd;
  logic        loc_wr, soft_rst_q, soft_rst_d;
  logic        ack_q;
  logic [15:0] rdata_q;

  // Third MDC stage only feeds edge detection; MDIO is aligned with stage 2.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '1;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[1:0], mdc_i};
      mdio_sync_q <= {mdio_sync_q[0], mdio_i};
    end
  end

  assign bit_evt = mdc_sync_q[1] & ~mdc_sync_q[2];
  assign bit_val = mdio_sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      bit_cnt_q <= '0;
      is_read_q <= 1'b0;
      phyad_q   <= '0;
      regad_q   <= '0;
      shift_q   <= '0;
      oe_q      <= 1'b0;
      mdo_q     <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      is_read_q <= is_read_d;
      phyad_q   <= phyad_d;
      regad_q   <= regad_d;
      shift_q   <= shift_d;
      oe_q      <= oe_d;
      mdo_q     <= mdo_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    is_read_d  = is_read_q;
    phyad_d    = phyad_q;
    regad_d    = regad_q;
    shift_d    = shift_q;
    oe_d       = oe_q;
    mdo_d      = mdo_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mdio_we    = 1'b0;
    mdio_wdata = {shift_q[14:0], bit_val};
    if (bit_evt) begin
      case (state_q)
        S_IDLE: begin
          if (bit_val) begin
            if (pre_cnt_q < PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
          end else begin
            if (pre_cnt_q == PRE_MAX) state_d = S_ST;
            pre_cnt_d = '0;
          end
        end
        S_ST: begin
          if (bit_val) begin
            state_d   = S_OP;
            bit_cnt_d = '0;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_OP: begin
          shift_d = {shift_q[14:0], bit_val};
          if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
          end else begin
            bit_cnt_d = '0;
            case ({shift_q[0], bit_val})
              2'b10:   begin is_read_d = 1'b1; state_d = S_PHYAD; end
              2'b01:   begin is_read_d = 1'b0; state_d = S_PHYAD; end
              default: begin err_d = 1'b1;     state_d = S_IDLE;  end
            endcase
          end
        end
        S_PHYAD: begin
          shift_d = {shift_q[14:0], bit_val};
          if (bit_cnt_q == 5'd4) begin
            phyad_d   = {shift_q[3:0], bit_val};
            bit_cnt_d = '0;
            state_d   = S_REGAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_REGAD: begin
          shift_d = {shift_q[14:0], bit_val};
          if (bit_cnt_q == 5'd4) begin
            regad_d   = {shift_q[3:0], bit_val};
            bit_cnt_d = '0;
            state_d   = (phyad_q != phy_addr_i) ? S_SKIP : S_TA;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_SKIP: begin
          if (bit_cnt_q == 5'd17) state_d = S_IDLE;
          else                    bit_cnt_d = bit_cnt_q + 1'b1;
        end
        S_TA: begin
          if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
          end else begin
            bit_cnt_d = '0;
            if (is_read_q) begin
              oe_d    = 1'b1;
              mdo_d   = 1'b0;
              shift_d = rf_rd[regad_q];
              state_d = S_RDATA;
            end else begin
              state_d = S_WDATA;
            end
          end
        end
        S_RDATA: begin
          if (bit_cnt_q == 5'd16) begin
            oe_d    = 1'b0;
            mdo_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            mdo_d     = shift_q[15];
            shift_d   = {shift_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_WDATA: begin
          shift_d = {shift_q[14:0], bit_val};
          if (bit_cnt_q == 5'd15) begin
            mdio_we = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign loc_wr = loc.loc_stb_i & loc.loc_we_i;

  // A bit-15 write to reg 0 lands for one cycle, then clears the whole file.
  always_comb begin
    soft_rst_d = 1'b0;
    if (mdio_we && regad_q == 5'd0)
      soft_rst_d = mdio_wdata[15];
    else if (loc_wr && loc.loc_addr_i == 5'd0)
      soft_rst_d = loc.loc_data_i[15];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) soft_rst_q <= 1'b0;
    else       soft_rst_q <= soft_rst_d;
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_reg
    localparam logic [4:0] IDX = 5'(gi);
    if (gi == 2) begin : g_id1
      assign rf_rd[gi] = PHY_ID1;
    end else if (gi == 3) begin : g_id2
      assign rf_rd[gi] = PHY_ID2;
    end else begin : g_rw
      logic [15:0] val_q;
      always_ff @(posedge clk_i) begin
        if (rst_i || soft_rst_q)
          val_q <= '0;
        else if (mdio_we && regad_q == IDX)
          val_q <= mdio_wdata;
        else if (loc_wr && loc.loc_addr_i == IDX)
          val_q <= loc.loc_data_i;
      end
      assign rf_rd[gi] = val_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= loc.loc_stb_i;
      if (loc.loc_stb_i && !loc.loc_we_i) rdata_q <= rf_rd[loc.loc_addr_i];
    end
  end

  assign loc.loc_ack_o  = ack_q;
  assign loc.loc_data_o = rdata_q;

  // Reset releases the pin combinationally so a mid-frame abort frees the bus at once.
  assign mdio_oe      = oe_q & ~rst_i;
  assign mdio_o       = mdo_q | rst_i;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_mdio_reg_responder.sv
// Self-checking bench for mdio_reg_responder: a bit-banged MDIO master plus the
// local port, with expected read data queued at issue and compared on response.
`timescale 1ns/1ps
module tb_mdio_reg_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic [4:0]  phy_addr;
  logic        frame_done;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  int err_total = 0;
  int oe_total = 0;
  int d0_m, e0_m;
  logic so_m, sd_m;
  logic [15:0] exp_q[$];

  mdio_reg_responder_if lif();

  always #5 clk = ~clk;

  mdio_reg_responder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mdc_i        (mdc),
    .mdio_i       (mdio_in),
    .mdio_o       (mdio_out),
    .mdio_oe      (mdio_oe),
    .phy_addr_i   (phy_addr),
    .loc          (lif),
    .frame_done_o (frame_done),
    .frame_err_o  (frame_err)
  );

  always @(negedge clk) begin
    if (frame_done) done_total++;
    if (frame_err)  err_total++;
    if (mdio_oe)    oe_total++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic loc_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    lif.loc_addr_i = a;
    lif.loc_data_i = d;
    lif.loc_we_i   = 1'b1;
    lif.loc_stb_i  = 1'b1;
    @(negedge clk);
    lif.loc_stb_i  = 1'b0;
    lif.loc_we_i   = 1'b0;
    check_eq("loc_wr_ack", 32'(lif.loc_ack_o), 32'd1);
    $display("loc write reg %0d = %h", a, d);
  endtask

  task automatic loc_read(input logic [4:0] a, input logic [15:0] exp);
    logic [15:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    lif.loc_addr_i = a;
    lif.loc_we_i   = 1'b0;
    lif.loc_stb_i  = 1'b1;
    @(negedge clk);
    lif.loc_stb_i  = 1'b0;
    check_eq("loc_rd_ack", 32'(lif.loc_ack_o), 32'd1);
    e = exp_q.pop_front();
    check_eq($sformatf("loc_rd_r%0d", a), 32'(lif.loc_data_o), 32'(e));
    $display("loc read  reg %0d = %h (exp %h)", a, lif.loc_data_o, e);
  endtask

  // One MDC period; returns the pin state seen just before the rising edge.
  task automatic mdc_bit(input logic b, output logic s_oe, output logic s_o);
    mdio_in = b;
    repeat (8) @(negedge clk);
    s_oe = mdio_oe;
    s_o  = mdio_out;
    mdc  = 1'b1;
    repeat (8) @(negedge clk);
    mdc  = 1'b0;
  endtask

  task automatic send_header(input int pre, input logic [1:0] op,
                             input logic [4:0] pa, input logic [4:0] ra);
    logic [13:0] hdr;
    logic so, sd;
    hdr = {2'b01, op, pa, ra};
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, so, sd);
    for (int i = 13; i >= 0; i--) mdc_bit(hdr[i], so, sd);
  endtask

  task automatic mdio_read(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] exp, input bit resp, input int abort_at);
    logic so, sd;
    logic [15:0] got, e;
    int d0, e0, o0;
    got = '0;
    d0 = done_total; e0 = err_total; o0 = oe_total;
    if (resp) exp_q.push_back(exp);
    send_header(pre, 2'b10, pa, ra);
    for (int i = 0; i < 2; i++) begin
      mdc_bit(1'b1, so, sd);
      if (resp) check_eq("rd_ta_z", 32'(so), 32'd0);
    end
    for (int i = 0; i < 17; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check_eq("rst_oe_release", 32'(mdio_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        if (resp) void'(exp_q.pop_back());
        $display("mdio read phy %0d reg %0d aborted by reset after %0d data bits", pa, ra, i);
        return;
      end
      mdc_bit(1'b1, so, sd);
      if (i == 0) begin
        if (resp) begin
          check_eq("rd_ta_oe", 32'(so), 32'd1);
          check_eq("rd_ta_zero", 32'(sd), 32'd0);
        end
      end else begin
        got = {got[14:0], sd};
      end
    end
    repeat (4) @(negedge clk);
    check_eq("rd_oe_after", 32'(mdio_oe), 32'd0);
    check_eq("rd_err_pulses", 32'(err_total - e0), 32'd0);
    if (resp) begin
      e = exp_q.pop_front();
      check_eq($sformatf("mdio_rd_r%0d", ra), 32'(got), 32'(e));
      check_eq("rd_done_pulses", 32'(done_total - d0), 32'd1);
      $display("mdio read phy %0d reg %0d = %h (exp %h)", pa, ra, got, e);
    end else begin
      check_eq("noresp_oe_cycles", 32'(oe_total - o0), 32'd0);
      check_eq("noresp_done", 32'(done_total - d0), 32'd0);
      $display("mdio read phy %0d reg %0d preamble %0d: no response expected", pa, ra, pre);
    end
  endtask

  task automatic mdio_write(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] d);
    logic so, sd;
    int d0, o0;
    d0 = done_total; o0 = oe_total;
    send_header(32, 2'b01, pa, ra);
    mdc_bit(1'b1, so, sd);
    mdc_bit(1'b0, so, sd);
    for (int i = 15; i >= 0; i--) mdc_bit(d[i], so, sd);
    repeat (4) @(negedge clk);
    check_eq("wr_done_pulses", 32'(done_total - d0), 32'd1);
    check_eq("wr_oe_cycles", 32'(oe_total - o0), 32'd0);
    $display("mdio write phy %0d reg %0d = %h", pa, ra, d);
  endtask

  initial begin
    rst = 1'b1;
    mdc = 1'b0;
    mdio_in = 1'b1;
    phy_addr = 5'd4;
    lif.loc_addr_i = '0;
    lif.loc_data_i = '0;
    lif.loc_we_i   = 1'b0;
    lif.loc_stb_i  = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mdio_oe", 32'(mdio_oe), 32'd0);
    check_eq("rst_mdio_o", 32'(mdio_out), 32'd1);
    check_eq("rst_loc_ack", 32'(lif.loc_ack_o), 32'd0);
    check_eq("rst_loc_data", 32'(lif.loc_data_o), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_err", 32'(frame_err), 32'd0);
    $display("reset state sampled");

    loc_write(5'd10, 16'h55AA);
    loc_read(5'd10, 16'h55AA);
    mdio_read(32, 5'd4, 5'd10, 16'h55AA, 1'b1, -1);

    mdio_write(5'd4, 5'd11, 16'h1234);
    loc_read(5'd11, 16'h1234);

    mdio_read(32, 5'd4, 5'd2, 16'h001C, 1'b1, -1);
    mdio_read(32, 5'd4, 5'd3, 16'hC915, 1'b1, -1);
    mdio_write(5'd4, 5'd2, 16'hFFFF);
    loc_read(5'd3, 16'hC915);
    mdio_read(32, 5'd4, 5'd2, 16'h001C, 1'b1, -1);

    // Short preamble must be ignored; a proper frame right after must decode.
    mdio_read(31, 5'd4, 5'd10, 16'h0000, 1'b0, -1);
    mdio_read(32, 5'd4, 5'd10, 16'h55AA, 1'b1, -1);

    mdio_read(32, 5'd5, 5'd10, 16'h0000, 1'b0, -1);

    d0_m = done_total; e0_m = err_total;
    for (int i = 0; i < 32; i++) mdc_bit(1'b1, so_m, sd_m);
    mdc_bit(1'b0, so_m, sd_m);
    mdc_bit(1'b1, so_m, sd_m);
    mdc_bit(1'b1, so_m, sd_m);
    mdc_bit(1'b1, so_m, sd_m);
    repeat (4) @(negedge clk);
    check_eq("op11_err_pulse", 32'(err_total - e0_m), 32'd1);
    check_eq("op11_no_done", 32'(done_total - d0_m), 32'd0);
    $display("mdio frame with op 11 sent");
    mdio_read(32, 5'd4, 5'd11, 16'h1234, 1'b1, -1);

    mdio_read(32, 5'd4, 5'd10, 16'h55AA, 1'b1, 8);
    loc_read(5'd10, 16'h0000);
    loc_read(5'd11, 16'h0000);
    loc_read(5'd2, 16'h001C);
    mdio_read(32, 5'd4, 5'd3, 16'hC915, 1'b1, -1);

    loc_write(5'd10, 16'hAAAA);
    mdio_write(5'd4, 5'd11, 16'h5A5A);
    loc_read(5'd11, 16'h5A5A);
    mdio_write(5'd4, 5'd0, 16'h8000);
    loc_read(5'd0, 16'h0000);
    loc_read(5'd10, 16'h0000);
    loc_read(5'd11, 16'h0000);
    loc_read(5'd2, 16'h001C);
    loc_read(5'd3, 16'hC915);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
